mul_seq_xnyn: RTL and testbench
===============================

MUL_SEQ_XNYN -- requirements
Module: mul_seq_xnyn

Interface
REQ-001 SHALL have parameter X_WIDTH, default 8, multiplicand width in bits, legal range >= 2.
REQ-002 SHALL have parameter Y_WIDTH, default 8, multiplier width in bits, legal range >= 2.
REQ-003 SHALL derive P_WIDTH = X_WIDTH + Y_WIDTH as a localparam; it is not user-settable.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-006 SHALL have port in_valid  input  1  operand request.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port x  input  X_WIDTH  multiplicand.
REQ-009 SHALL have port y  input  Y_WIDTH  multiplier.
REQ-010 SHALL have port is_signed  input  1  selects the operand encoding: 1 = two's complement, 0 = unsigned; sampled with x and y.
REQ-011 SHALL have port out_valid  output  1  product available on p.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-013 SHALL have port p  output  P_WIDTH  registered product.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in BUSY, DONE or while rst=1, in_ready SHALL be 0.
REQ-016 Input handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1; that edge captures x, y and is_signed, clears the accumulator and iteration count, and moves the FSM to BUSY.
REQ-017 Operand conversion at capture: when is_signed=1, SHALL latch |x| and |y| (zero-extended by one bit so that the minimum negative value is exact) and store the result sign = x[MSB] XOR y[MSB]; when is_signed=0, operands are latched as-is and the sign is 0.
REQ-018 In BUSY, each rising edge SHALL perform one shift-add iteration over one multiplier bit, LSB first: add the shifted multiplicand to the accumulator when that multiplier bit is 1.
REQ-019 BUSY SHALL last exactly Y_WIDTH rising edges regardless of operand values, including zero operands; there is no early termination.
REQ-020 On the final iteration edge, SHALL load p with the accumulator result, two's-complement negated when the stored sign is 1, set out_valid=1 and move to DONE.
REQ-021 Latency: out_valid SHALL first be observed high exactly Y_WIDTH clocks after the accepting edge.
REQ-022 In DONE, p and out_valid SHALL hold stable until a rising edge with out_ready=1, which clears out_valid and returns the FSM to IDLE.
REQ-023 No accept in the release cycle: in_ready is 0 in DONE, so a new operand is accepted no earlier than the edge after the output handshake; minimum throughput is one product per Y_WIDTH+2 clocks.
REQ-024 p SHALL retain the last product after the output handshake until the next result load.
REQ-025 Changes on x, y, is_signed or in_valid outside an accepting edge SHALL have no effect on state or p.
REQ-026 Arithmetic SHALL be exact mod 2^P_WIDTH; no overflow is possible, including for signed min*min = 2^(P_WIDTH-2).
REQ-027 The iteration counter SHALL be clog2(Y_WIDTH+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 A rising edge with rst=1 SHALL force state=IDLE, p=0, out_valid=0, clear the accumulator, counter and sign, and discard any in-flight operation.
REQ-029 On the first edge after rst deasserts, in_ready SHALL be 1; an in_valid held high through reset SHALL NOT be accepted on a reset edge.

Verification (defaults X_WIDTH = Y_WIDTH = 8)
REQ-030 Unsigned: x=13, y=11, is_signed=0 accepted -> out_valid high 8 clocks later with p=0x008F; x=255, y=255 -> p=0xFE01.
REQ-031 Signed: x=0xFD (-3), y=0x05 -> p=0xFFF1; x=0x80, y=0x80 -> p=0x4000; x=0x00, y=0x80 -> p=0x0000 after the full 8 clocks.
REQ-032 Backpressure: out_ready held 0 for 5 clocks in DONE -> p and out_valid stable, in_ready=0, and a pulsed in_valid is ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 Reset mid-operation: rst=1 on the 4th BUSY edge -> next cycle p=0, out_valid=0, in_ready=1; a new 2*3 unsigned request -> p=0x0006 with normal latency.
REQ-034 Back-to-back: in_valid held 1 continuously with out_ready held 1 -> an accept every Y_WIDTH+2 clocks, each product correct, and no accept in the DONE cycle.
REQ-035 Parameter sweep: X_WIDTH=4, Y_WIDTH=6 with random signed and unsigned operands against a reference model -> all products exact and latency = 6 clocks.

Source files
------------

// File: rtl/mul_seq_xnyn.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first,
// with sign-magnitude handling for two's-complement operands and valid/ready handshakes.
module mul_seq_xnyn #(
    parameter  int X_WIDTH = 8,
    parameter  int Y_WIDTH = 8,
    localparam int P_WIDTH = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(Y_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Y_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [P_WIDTH-1:0] acc, x_sh, addend, acc_sum;
    logic [Y_WIDTH:0]   y_sh;
    logic [CNT_W-1:0]   cnt;
    logic               sign;
    logic               accept;

    // One extra bit keeps the magnitude of the most negative operand exact.
    logic [X_WIDTH:0] x_ext, x_mag;
    logic [Y_WIDTH:0] y_ext, y_mag;

    always_comb begin
        x_ext = {is_signed & x[X_WIDTH-1], x};
        y_ext = {is_signed & y[Y_WIDTH-1], y};
        x_mag = x_ext[X_WIDTH] ? -x_ext : x_ext;
        y_mag = y_ext[Y_WIDTH] ? -y_ext : y_ext;
    end

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign addend   = y_sh[0] ? x_sh : '0;
    assign acc_sum  = acc + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)       state_next = BUSY;
            BUSY:    if (cnt == LAST)    state_next = DONE;
            DONE:    if (out_ready)      state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            x_sh      <= '0;
            y_sh      <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            acc  <= '0;
            cnt  <= '0;
            x_sh <= {{(Y_WIDTH - 1){1'b0}}, x_mag};
            y_sh <= y_mag;
            sign <= is_signed & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
        end else if (state == BUSY) begin
            acc  <= acc_sum;
            x_sh <= x_sh << 1;
            y_sh <= y_sh >> 1;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                p         <= sign ? -acc_sum : acc_sum;
                out_valid <= 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_seq_xnyn.sv
// Bench for mul_seq_xnyn: 8x8 instance with directed vectors and a 4x6 instance
// with a mixed sweep, both checked every cycle against a transaction-level model.
module tb_mul_seq_xnyn;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
    end

    // 8x8 instance
    logic        a_in_valid = 1'b0, a_in_ready, a_s = 1'b0, a_out_valid, a_out_ready = 1'b0;
    logic [7:0]  a_x = '0, a_y = '0;
    logic [15:0] a_p;

    mul_seq_xnyn #(.X_WIDTH(8), .Y_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .is_signed(a_s), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .p(a_p)
    );

    // 4x6 instance
    logic       b_in_valid = 1'b0, b_in_ready, b_s = 1'b0, b_out_valid, b_out_ready = 1'b0;
    logic [3:0] b_x = '0;
    logic [5:0] b_y = '0;
    logic [9:0] b_p;

    mul_seq_xnyn #(.X_WIDTH(4), .Y_WIDTH(6)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .is_signed(b_s), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .p(b_p)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_a(input logic [7:0] xv, input logic [7:0] yv, input bit s);
        int xi, yi;
        xi = s ? int'($signed(xv)) : int'(xv);
        yi = s ? int'($signed(yv)) : int'(yv);
        return 16'(xi * yi);
    endfunction

    function automatic logic [9:0] ref_b(input logic [3:0] xv, input logic [5:0] yv, input bit s);
        int xi, yi;
        xi = s ? int'($signed(xv)) : int'(xv);
        yi = s ? int'($signed(yv)) : int'(yv);
        return 10'(xi * yi);
    endfunction

    // Transaction model: a request is taken only when idle and out of reset,
    // the exact product appears Y_WIDTH clocks later and stays until released.
    int          ma_left = 0, mb_left = 0;
    bit          ma_done = 1'b0, mb_done = 1'b0;
    logic [15:0] ma_p = '0, ma_res = '0;
    logic [9:0]  mb_p = '0, mb_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            ma_left = 0; ma_done = 1'b0; ma_p = '0;
        end else if (ma_done) begin
            if (a_out_ready) ma_done = 1'b0;
        end else if (ma_left > 0) begin
            ma_left--;
            if (ma_left == 0) begin ma_done = 1'b1; ma_p = ma_res; end
        end else if (a_in_valid) begin
            ma_left = 8;
            ma_res  = ref_a(a_x, a_y, a_s);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mb_left = 0; mb_done = 1'b0; mb_p = '0;
        end else if (mb_done) begin
            if (b_out_ready) mb_done = 1'b0;
        end else if (mb_left > 0) begin
            mb_left--;
            if (mb_left == 0) begin mb_done = 1'b1; mb_p = mb_res; end
        end else if (b_in_valid) begin
            mb_left = 6;
            mb_res  = ref_b(b_x, b_y, b_s);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a_in_ready",  a_in_ready,  !rst && ma_left == 0 && !ma_done);
            chk("a_out_valid", a_out_valid, ma_done);
            chk("a_p",         a_p,         ma_p);
            chk("b_in_ready",  b_in_ready,  !rst && mb_left == 0 && !mb_done);
            chk("b_out_valid", b_out_valid, mb_done);
            chk("b_p",         b_p,         mb_p);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic [7:0] xv, input logic [7:0] yv, input bit sv,
                        input logic [15:0] expv, input bit release_out);
        int n;
        n = 0;
        while (!a_in_ready && n < 40) begin tick(); n++; end
        chk("a_ready_wait", 32'(n < 40), 32'd1);
        a_x = xv; a_y = yv; a_s = sv; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_x = 8'($urandom); a_y = 8'($urandom); a_s = 1'($urandom);
        n = 0;
        while (!a_out_valid && n < 40) begin tick(); n++; end
        chk("a_latency", n, 8);
        chk("a_product", a_p, expv);
        if (release_out) begin
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
        end
    endtask

    task automatic op_b(input logic [3:0] xv, input logic [5:0] yv, input bit sv);
        int n;
        logic [9:0] expv;
        expv = ref_b(xv, yv, sv);
        n = 0;
        while (!b_in_ready && n < 40) begin tick(); n++; end
        chk("b_ready_wait", 32'(n < 40), 32'd1);
        b_x = xv; b_y = yv; b_s = sv; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 40) begin tick(); n++; end
        chk("b_latency", n, 6);
        chk("b_product", b_p, expv);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    logic [7:0] bbx [4] = '{8'd7, 8'hFF, 8'h80, 8'd200};
    logic [7:0] bby [4] = '{8'd9, 8'h02, 8'h7F, 8'd3};
    bit         bbs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int         acc_t [4];

    initial begin
        int n;
        // Reset with a request held high: it must not be taken on a reset edge.
        a_in_valid = 1'b1; a_x = 8'd13; a_y = 8'd11; a_s = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_p", a_p, 16'h0000);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1'b1);
        op_a(8'd13, 8'd11, 1'b0, 16'h008F, 1'b1);
        op_a(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
        op_a(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        op_a(8'h00, 8'h80, 1'b1, 16'h0000, 1'b1);
        op_a(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);

        // Backpressure in DONE with a stray request pulse.
        op_a(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = (i == 2);
            a_x = 8'h11; a_y = 8'h22;
            tick();
            chk("bp_out_valid", a_out_valid, 1'b1);
            chk("bp_p", a_p, 16'hFFF1);
            chk("bp_in_ready", a_in_ready, 1'b0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("release_in_ready", a_in_ready, 1'b1);
        chk("release_out_valid", a_out_valid, 1'b0);
        chk("release_p_hold", a_p, 16'hFFF1);

        // Reset landing on the 4th BUSY edge.
        a_x = 8'd50; a_y = 8'd7; a_s = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("midrst_p", a_p, 16'h0000);
        chk("midrst_out_valid", a_out_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", a_in_ready, 1'b1);
        op_a(8'd2, 8'd3, 1'b0, 16'h0006, 1'b1);

        // Back-to-back with both handshakes held high.
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_x = bbx[i]; a_y = bby[i]; a_s = bbs[i];
            n = 0;
            while (!a_in_ready && n < 30) begin tick(); n++; end
            chk("b2b_ready_wait", 32'(n < 30), 32'd1);
            tick();
            acc_t[i] = cyc;
            if (i > 0) chk("b2b_interval", acc_t[i] - acc_t[i-1], 10);
        end
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 20) begin tick(); n++; end
        chk("b2b_last_product", a_p, 16'h0258);
        tick();
        a_out_ready = 1'b0;

        // 4x6 sweep: boundaries then random mixed-encoding operands.
        op_b(4'h8, 6'h20, 1'b1);
        op_b(4'hF, 6'h3F, 1'b0);
        op_b(4'hF, 6'h3F, 1'b1);
        op_b(4'h0, 6'h20, 1'b1);
        for (int i = 0; i < 16; i++)
            op_b(4'($urandom), 6'($urandom), 1'($urandom));
        chk("b_minmin_pin", 32'(ref_b(4'h8, 6'h20, 1'b1)), 32'h100);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
